addsub_arbiter: RTL

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arbiter.sv | 96 +++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of one shared add/subtract
// datapath. Results go into a single-entry registered buffer.
module addsub_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic             ptr;
  logic             grant0;
  logic             grant1;
  logic             slot_free;
  logic             accept;
  logic             sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sub;
  logic [WIDTH:0]   result;

  // Round-robin pick: a lone requester wins; under contention the one not
  // named by the last-grant pointer wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || ptr);
    grant1 = req1_valid && (!req0_valid || !ptr);
  end

  assign slot_free = (state == EMPTY) || rsp_ready;
  assign accept    = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel       = req1_ready;

  // Shared datapath: subtract is a + ~b + 1, carry doubles as no-borrow.
  always_comb begin
    op_a   = sel ? req1_a   : req0_a;
    op_b   = sel ? req1_b   : req0_b;
    op_sub = sel ? req1_sub : req0_sub;
    result = {1'b0, op_a} + {1'b0, (op_sub ? ~op_b : op_b)} + {{WIDTH{1'b0}}, op_sub};
  end

  // State register for the result buffer occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Next-state: fill on accept, empty on drain without a refill.
  always_comb begin
    state_next = state;
    unique case (state)
      EMPTY:   if (accept) state_next = FULL;
      FULL:    if (rsp_ready && !accept) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  // Outputs: readies are masked during reset so nothing is granted then.
  always_comb begin
    rsp_valid  = (state == FULL);
    req0_ready = rst_n && slot_free && grant0;
    req1_ready = rst_n && slot_free && grant1;
  end

  // Result buffer and last-grant pointer, loaded only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'b1;
      rsp_id    <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
    end else if (accept) begin
      ptr                  <= sel;
      rsp_id               <= sel;
      {rsp_carry, rsp_sum} <= result;
    end
  end

endmodule
